// File: rtl/serial_result_sender_if.sv
// Handshake and data bundle between the result sender and the HPS-facing PIO side.
interface serial_result_sender_if #(
    parameter int NUM_WORDS  = 8,
    parameter int WORD_WIDTH = 32
);
    logic [NUM_WORDS*WORD_WIDTH-1:0] iResults;
    logic [7:0]                      iWordCount;
    logic                            iStart;
    logic                            iWordRead;
    logic                            iDoneFeedback;
    logic                            oReady;
    logic                            oWordValid;
    logic [7:0]                      oWordIndex;
    logic [WORD_WIDTH-1:0]           oWordData;
    logic                            oDone;
    logic [WORD_WIDTH-1:0]           oChecksum;
    logic [2:0]                      oState;

    modport master (
        input  iResults, iWordCount, iStart, iWordRead, iDoneFeedback,
        output oReady, oWordValid, oWordIndex, oWordData, oDone, oChecksum, oState
    );

    modport slave (
        output iResults, iWordCount, iStart, iWordRead, iDoneFeedback,
        input  oReady, oWordValid, oWordIndex, oWordData, oDone, oChecksum, oState
    );
endinterface

// File: rtl/serial_result_sender.sv
// Sends a snapshot of result words to the HPS one at a time over a four-phase
// PIO handshake, accumulating a wrapping checksum of the words sent.
module serial_result_sender #(
    parameter int NUM_WORDS  = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                    iClock,
    input  logic                    iReset,
    serial_result_sender_if.master  bus
);
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESENT      = 3'd1,
        ST_RELEASE      = 3'd2,
        ST_DONE         = 3'd3,
        ST_DONE_RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] MAX_COUNT = 8'(NUM_WORDS);

    state_t                          state_q, state_d;
    logic [NUM_WORDS*WORD_WIDTH-1:0] buf_q, buf_d;
    logic [7:0]                      count_q, count_d;
    logic [7:0]                      index_q, index_d;
    logic [WORD_WIDTH-1:0]           checksum_q, checksum_d;
    logic                            ready_q, ready_d;
    logic                            valid_q, valid_d;
    logic                            done_q, done_d;
    logic [7:0]                      word_index_q, word_index_d;
    logic [WORD_WIDTH-1:0]           word_data_q, word_data_d;
    logic [WORD_WIDTH-1:0]           cur_word;

    assign cur_word = buf_q[32'(index_q)*WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        index_d    = index_q;
        checksum_d = checksum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    buf_d      = bus.iResults;
                    count_d    = (bus.iWordCount > MAX_COUNT) ? MAX_COUNT : bus.iWordCount;
                    index_d    = '0;
                    checksum_d = '0;
                    state_d    = (count_d != '0) ? ST_PRESENT : ST_DONE;
                end
            end
            ST_PRESENT: begin
                if (bus.iWordRead) begin
                    checksum_d = checksum_q + cur_word;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.iWordRead) begin
                    if (index_q + 8'd1 == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = ST_PRESENT;
                    end
                end
            end
            ST_DONE: begin
                if (bus.iDoneFeedback) state_d = ST_DONE_RELEASE;
            end
            ST_DONE_RELEASE: begin
                if (!bus.iDoneFeedback) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ready_d      = (state_d == ST_IDLE);
        valid_d      = (state_d == ST_PRESENT);
        done_d       = (state_d == ST_DONE);
        word_index_d = '0;
        word_data_d  = '0;
        if (state_d == ST_PRESENT || state_d == ST_RELEASE) begin
            word_index_d = index_d;
            word_data_d  = buf_d[32'(index_d)*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            checksum_q   <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            word_index_q <= '0;
            word_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            checksum_q   <= checksum_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            word_index_q <= word_index_d;
            word_data_q  <= word_data_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge iClock) begin
        buf_q <= buf_d;
    end

    assign bus.oReady     = ready_q;
    assign bus.oWordValid = valid_q;
    assign bus.oWordIndex = word_index_q;
    assign bus.oWordData  = word_data_q;
    assign bus.oDone      = done_q;
    assign bus.oChecksum  = checksum_q;
    assign bus.oState     = state_q;
endmodule

// File: tb/tb_serial_result_sender.sv
// Plays the HPS side of the word handshake against a queue-based model of the transfer.
module tb_serial_result_sender;
    localparam int NW = 8;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [WW-1:0] words [NW];

    always #5 clk = ~clk;

    serial_result_sender_if #(.NUM_WORDS(NW), .WORD_WIDTH(WW)) bus ();

    serial_result_sender #(.NUM_WORDS(NW), .WORD_WIDTH(WW)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.oReady), 64'd1);
        chk({tag, "_valid"}, 64'(bus.oWordValid), 64'd0);
        chk({tag, "_done"},  64'(bus.oDone), 64'd0);
        chk({tag, "_index"}, 64'(bus.oWordIndex), 64'd0);
        chk({tag, "_data"},  64'(bus.oWordData), 64'd0);
        chk({tag, "_cks"},   64'(bus.oChecksum), 64'd0);
        chk({tag, "_state"}, 64'(bus.oState), 64'd0);
    endtask

    // One complete transfer as seen from the HPS. abort_at >= 0 resets the
    // block on the first RELEASE cycle of that word index.
    task automatic run_transfer(input int wc, input int hold_max, input bit disturb,
                                input bit early_read, input int abort_at);
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] sum;
        int n;
        int h;
        n   = (wc > NW) ? NW : wc;
        sum = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(words[i]);
        for (int i = 0; i < NW; i++) bus.iResults[i*WW +: WW] = words[i];
        bus.iWordCount = 8'(wc);
        bus.iStart     = 1'b1;
        bus.iWordRead  = early_read;
        step();
        bus.iStart = 1'b0;
        chk("ready_low", 64'(bus.oReady), 64'd0);
        if (n == 0) begin
            chk("empty_state", 64'(bus.oState), 64'd3);
            chk("empty_valid", 64'(bus.oWordValid), 64'd0);
        end
        for (int k = 0; k < n; k++) begin
            chk("pres_valid", 64'(bus.oWordValid), 64'd1);
            chk("pres_state", 64'(bus.oState), 64'd1);
            chk("pres_index", 64'(bus.oWordIndex), 64'(k));
            chk("pres_data",  64'(bus.oWordData), 64'(exp_q[k]));
            bus.iWordRead = 1'b1;
            h   = disturb ? hold_max : int'($urandom_range(hold_max, 1));
            sum = sum + exp_q[k];
            for (int c = 0; c < h; c++) begin
                if (disturb) begin
                    for (int i = 0; i < NW; i++) bus.iResults[i*WW +: WW] = $urandom;
                    bus.iStart = (c == h / 2);
                end
                step();
                chk("rel_valid", 64'(bus.oWordValid), 64'd0);
                chk("rel_state", 64'(bus.oState), 64'd2);
                chk("rel_index", 64'(bus.oWordIndex), 64'(k));
                chk("rel_data",  64'(bus.oWordData), 64'(exp_q[k]));
                chk("rel_cks",   64'(bus.oChecksum), 64'(sum));
                if (k == abort_at && c == 0) begin
                    bus.iStart = 1'b0;
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    bus.iWordRead = 1'b0;
                    chk_reset_outputs("abort");
                    return;
                end
            end
            bus.iStart    = 1'b0;
            bus.iWordRead = 1'b0;
            step();
        end
        chk("done_flag",  64'(bus.oDone), 64'd1);
        chk("done_state", 64'(bus.oState), 64'd3);
        chk("done_valid", 64'(bus.oWordValid), 64'd0);
        chk("done_index", 64'(bus.oWordIndex), 64'd0);
        chk("done_data",  64'(bus.oWordData), 64'd0);
        chk("done_cks",   64'(bus.oChecksum), 64'(sum));
        bus.iDoneFeedback = 1'b1;
        h = int'($urandom_range(3, 1));
        for (int c = 0; c < h; c++) begin
            step();
            chk("dr_state", 64'(bus.oState), 64'd4);
            chk("dr_done",  64'(bus.oDone), 64'd0);
        end
        bus.iDoneFeedback = 1'b0;
        step();
        chk("idle_state", 64'(bus.oState), 64'd0);
        chk("idle_ready", 64'(bus.oReady), 64'd1);
        chk("idle_cks",   64'(bus.oChecksum), 64'(sum));
        chk("idle_data",  64'(bus.oWordData), 64'd0);
    endtask

    initial begin
        bus.iResults      = '0;
        bus.iWordCount    = '0;
        bus.iStart        = 1'b0;
        bus.iWordRead     = 1'b0;
        bus.iDoneFeedback = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();
        chk_reset_outputs("post_reset");

        for (int i = 0; i < NW; i++) words[i] = 32'h10 + 32'(i);
        run_transfer(8, 3, 1'b0, 1'b0, -1);

        run_transfer(0, 1, 1'b0, 1'b0, -1);

        for (int i = 0; i < NW; i++) words[i] = '0;
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h0000_0002;
        run_transfer(20, 2, 1'b0, 1'b0, -1);

        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_transfer(8, 50, 1'b1, 1'b0, -1);

        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_transfer(8, 2, 1'b0, 1'b0, 3);
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_transfer(6, 2, 1'b0, 1'b0, -1);

        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_transfer(5, 3, 1'b0, 1'b1, -1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NW; i++) words[i] = $urandom;
            run_transfer(int'($urandom_range(12, 0)), 4, 1'b0, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
